// File: rtl/z16_sequencer.sv
// Z16 multi-cycle control sequencer: owns PC/IR and walks FETCH-DECODE-EXEC-MEM/WB.
// Optional handshake watchdog enabled by defining Z16_BUS_TIMEOUT_EN.
module z16_sequencer #(
  parameter logic [15:0] PC_RESET       = 16'h0000,
  parameter int          TIMEOUT_CYCLES = 15
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_run,
  output logic        o_imem_req,
  output logic [15:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [15:0] i_imem_rdata,
  output logic [15:0] o_instr,
  input  logic        i_rd_wen,
  input  logic        i_mem_wen,
  input  logic        i_pc_load,
  input  logic [15:0] i_pc_target,
  output logic        o_dmem_req,
  input  logic        i_dmem_ack,
  output logic        o_rf_we,
  output logic [15:0] o_pc,
  output logic        o_retire,
  output logic [2:0]  o_state,
  output logic        o_bus_err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_next;
  state_t      w_after;
  logic [15:0] r_pc;
  logic [15:0] r_instr;
  logic [15:0] r_pend_tgt;
  logic        r_pend_load;
  logic        r_retire;
  logic        w_retire;
  logic        w_timeout;
  logic        w_err_block;
  logic        w_load;
  logic [15:0] w_tgt;

`ifdef Z16_BUS_TIMEOUT_EN
  logic [7:0] r_wdog;
  logic       r_bus_err;
  logic       w_wait;

  assign w_wait      = ((r_state == S_FETCH) && !i_imem_ack) || ((r_state == S_MEM) && !i_dmem_ack);
  assign w_timeout   = w_wait && (r_wdog == 8'(TIMEOUT_CYCLES - 1));
  assign w_err_block = r_bus_err;
  assign o_bus_err   = r_bus_err;

  // Watchdog restarts on every state entry and only runs while waiting on a handshake.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wdog    <= 8'd0;
      r_bus_err <= 1'b0;
    end else begin
      if ((w_next != r_state) || !((r_state == S_FETCH) || (r_state == S_MEM))) begin
        r_wdog <= 8'd0;
      end else begin
        r_wdog <= r_wdog + 8'd1;
      end
      if (w_timeout) begin
        r_bus_err <= 1'b1;
      end
    end
  end
`else
  logic w_unused_timeout;

  assign w_unused_timeout = ^TIMEOUT_CYCLES;
  assign w_timeout        = 1'b0;
  assign w_err_block      = 1'b0;
  assign o_bus_err        = 1'b0;
`endif

  // A branch retiring straight out of EXEC has not latched its pending target yet.
  assign w_load  = (r_state == S_EXEC) ? i_pc_load   : r_pend_load;
  assign w_tgt   = (r_state == S_EXEC) ? i_pc_target : r_pend_tgt;
  assign w_after = i_run ? S_FETCH : S_IDLE;

  always_comb begin
    w_next   = r_state;
    w_retire = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_run && !w_err_block) w_next = S_FETCH;
        else                       w_next = S_IDLE;
      end
      S_FETCH: begin
        if (i_imem_ack)     w_next = S_DECODE;
        else if (w_timeout) w_next = S_IDLE;
        else                w_next = S_FETCH;
      end
      S_DECODE: w_next = S_EXEC;
      S_EXEC: begin
        if (i_mem_wen)     w_next = S_MEM;
        else if (i_rd_wen) w_next = S_WB;
        else begin
          w_next   = w_after;
          w_retire = 1'b1;
        end
      end
      S_MEM: begin
        if (i_dmem_ack) begin
          w_next   = w_after;
          w_retire = 1'b1;
        end else if (w_timeout) begin
          w_next = S_IDLE;
        end else begin
          w_next = S_MEM;
        end
      end
      S_WB: begin
        w_next   = w_after;
        w_retire = 1'b1;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_pc        <= PC_RESET;
      r_instr     <= 16'h0000;
      r_pend_load <= 1'b0;
      r_pend_tgt  <= 16'h0000;
      r_retire    <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_retire <= w_retire;
      if ((r_state == S_FETCH) && i_imem_ack) begin
        r_instr <= i_imem_rdata;
      end
      if (r_state == S_EXEC) begin
        r_pend_load <= i_pc_load;
        r_pend_tgt  <= i_pc_target;
      end
      if (w_retire) begin
        r_pc <= w_load ? w_tgt : (r_pc + 16'd2);
      end
    end
  end

  assign o_imem_req  = (r_state == S_FETCH);
  assign o_imem_addr = r_pc;
  assign o_instr     = r_instr;
  assign o_dmem_req  = (r_state == S_MEM);
  assign o_rf_we     = (r_state == S_WB);
  assign o_pc        = r_pc;
  assign o_retire    = r_retire;
  assign o_state     = r_state;

endmodule

// File: tb/tb_z16_sequencer.sv
// Directed self-checking bench for z16_sequencer; expected values are hand-computed.
module tb_z16_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] instr;
  logic        rd_wen;
  logic        mem_wen;
  logic        pc_load;
  logic [15:0] pc_target;
  logic        dmem_req;
  logic        dmem_ack;
  logic        rf_we;
  logic [15:0] pc;
  logic        retire;
  logic [2:0]  state;
  logic        bus_err;

  int checks   = 0;
  int failures = 0;
  int n_req;
  int n_we;

  always #5 clk = ~clk;

  z16_sequencer dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_run(run),
    .o_imem_req(imem_req), .o_imem_addr(imem_addr), .i_imem_ack(imem_ack),
    .i_imem_rdata(imem_rdata), .o_instr(instr), .i_rd_wen(rd_wen),
    .i_mem_wen(mem_wen), .i_pc_load(pc_load), .i_pc_target(pc_target),
    .o_dmem_req(dmem_req), .i_dmem_ack(dmem_ack), .o_rf_we(rf_we),
    .o_pc(pc), .o_retire(retire), .o_state(state), .o_bus_err(bus_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b1; imem_ack = 1'b1; imem_rdata = 16'h1230;
    rd_wen = 1'b1; mem_wen = 1'b0; pc_load = 1'b0; pc_target = 16'h0000; dmem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_state", 32'(state), 32'd0);
    check_eq("rst_addr", 32'(imem_addr), 32'h0000);
    check_eq("rst_outs", {27'd0, imem_req, dmem_req, rf_we, retire, bus_err}, 32'd0);
    check_eq("rst_instr", 32'(instr), 32'h0000);
    rst_n = 1'b1;

    // ADD with register write: FETCH, DECODE, EXEC, WB
    tick();
    check_eq("add_fetch_req", 32'(imem_req), 32'd1);
    check_eq("add_fetch_addr", 32'(imem_addr), 32'h0000);
    tick();
    check_eq("add_decode", {13'd0, state, instr}, {13'd0, 3'd2, 16'h1230});
    tick();
    check_eq("add_exec", 32'(state), 32'd3);
    tick();
    check_eq("add_wb_we", {30'd0, rf_we, retire}, {30'd0, 1'b1, 1'b0});
    imem_rdata = 16'h321B; rd_wen = 1'b0; mem_wen = 1'b1;
    tick();
    check_eq("add_retire", {15'd0, retire, rf_we, 15'd0}, {15'd0, 1'b1, 1'b0, 15'd0});
    check_eq("add_next_addr", {13'd0, state, imem_addr}, {13'd0, 3'd1, 16'h0002});

    // Store with dmem ack in the fourth MEM cycle
    tick();
    check_eq("st_instr", 32'(instr), 32'h321B);
    tick();
    tick();
    n_req = 0; n_we = 0;
    for (int i = 0; i < 4; i++) begin
      if (dmem_req) n_req++;
      if (rf_we) n_we++;
      if (i == 3) dmem_ack = 1'b1;
      tick();
    end
    dmem_ack = 1'b0;
    check_eq("st_req_cycles", 32'(n_req), 32'd4);
    check_eq("st_rf_we", 32'(n_we), 32'd0);
    check_eq("st_done", {15'd0, retire, dmem_req, imem_addr}, {15'd0, 1'b1, 1'b0, 16'h0004});

    // Taken branch out of EXEC on a no-write instruction: 3 cycles
    mem_wen = 1'b0; imem_rdata = 16'h5000; pc_load = 1'b1; pc_target = 16'h0040;
    tick();
    tick();
    check_eq("br_exec", 32'(state), 32'd3);
    tick();
    check_eq("br_retire", 32'(retire), 32'd1);
    check_eq("br_target", {13'd0, state, imem_addr}, {13'd0, 3'd1, 16'h0040});

    // Jump to FFFE to set up the wrap test
    pc_target = 16'hFFFE;
    repeat (3) tick();
    pc_load = 1'b0;
    check_eq("jmp_fffe", 32'(imem_addr), 32'hFFFE);

    // Wrap, with run dropped during DECODE
    rd_wen = 1'b1; imem_rdata = 16'h1230;
    tick();
    run = 1'b0;
    tick();
    tick();
    check_eq("wrap_wb", 32'(state), 32'd5);
    tick();
    check_eq("wrap_pc", {15'd0, retire, pc}, {15'd0, 1'b1, 16'h0000});
    check_eq("wrap_idle", {29'd0, state}, 32'd0);
    tick();
    check_eq("idle_hold", {28'd0, imem_req, state}, 32'd0);
    run = 1'b1;
    tick();
    check_eq("rerun_fetch", {13'd0, state, imem_addr}, {13'd0, 3'd1, 16'h0000});

    // Asynchronous reset while a store is waiting
    rd_wen = 1'b0; mem_wen = 1'b1;
    repeat (3) tick();
    check_eq("mid_st_req", 32'(dmem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_mid_req", 32'(dmem_req), 32'd0);
    check_eq("rst_mid_outs", {10'd0, imem_req, rf_we, retire, bus_err, state, instr},
             32'd0);
    check_eq("rst_mid_pc", {imem_addr, pc}, 32'h0000_0000);
    @(posedge clk);
    #1;
    mem_wen = 1'b0; imem_ack = 1'b0;
    rst_n = 1'b1;

    // Instruction memory that never acknowledges
    tick();
    n_req = 0;
    for (int i = 0; i < 40; i++) begin
      if (imem_req) n_req++;
      tick();
    end
`ifdef Z16_BUS_TIMEOUT_EN
    check_eq("to_fetch_cycles", 32'(n_req), 32'd15);
    check_eq("to_bus_err", {28'd0, bus_err, state}, {28'd0, 1'b1, 3'd0});
    check_eq("to_pc", 32'(pc), 32'h0000);
    rst_n = 1'b0;
    #1;
    check_eq("to_err_clear", 32'(bus_err), 32'd0);
`else
    check_eq("stall_fetch_cycles", 32'(n_req), 32'd40);
    check_eq("stall_no_err", {28'd0, bus_err, state}, {28'd0, 1'b0, 3'd1});
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
